spi_sensor_scheduler: RTL and testbench

Sequences periodic burst reads of the gyroscope and accelerometer over one shared byte-level SPI master and publishes each sample pair as a single 104-bit AXI-Stream frame. It owns both active-low chip selects and sits between the SPI byte engine and the attitude estimation datapath's stream input.

---
 rtl/spi_sensor_scheduler_if.sv | 23 ++
 rtl/spi_sensor_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_spi_sensor_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_sensor_scheduler_if.sv
// Signal bundle between the sensor scheduler, the shared SPI byte engine
// and the downstream AXI-Stream sink.
interface spi_sensor_scheduler_if;
    logic         byte_start;
    logic [7:0]   byte_tx;
    logic         byte_done;
    logic [7:0]   byte_rx;
    logic         SS_G;
    logic         SS_A;
    logic         TVALID;
    logic         TREADY;
    logic [103:0] TDATA;

    modport master (
        output byte_start, byte_tx, SS_G, SS_A, TVALID, TDATA,
        input  byte_done, byte_rx, TREADY
    );

    modport slave (
        input  byte_start, byte_tx, SS_G, SS_A, TVALID, TDATA,
        output byte_done, byte_rx, TREADY
    );
endinterface

// File: rtl/spi_sensor_scheduler.sv
// Periodic gyro-then-accel SPI burst reader that packs each sample pair
// into one 104-bit stream frame {seq, gyro, accel}.
module spi_sensor_scheduler #(
    parameter int         SAMPLE_DIV = 1000,
    parameter logic [7:0] GYRO_CMD   = 8'hE8,
    parameter logic [7:0] ACCEL_CMD  = 8'hE8,
    parameter int         CS_GAP     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    output logic [7:0]            overrun_cnt,
    spi_sensor_scheduler_if.master bus
);
    localparam int CNT_W = $clog2(SAMPLE_DIV);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CS_SETUP   = 3'd1,
        ST_CMD        = 3'd2,
        ST_DATA       = 3'd3,
        ST_CS_RELEASE = 3'd4,
        ST_GAP        = 3'd5,
        ST_OUTPUT     = 3'd6
    } state_t;

    state_t           state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [2:0]       byte_idx_r;
    logic             sel_r, sel_nx_s;
    logic [47:0]      gyro_r, accel_r;
    logic [7:0]       seq_r, overrun_r, byte_tx_r, issue_tx_s;
    logic             byte_start_r, ss_g_r, ss_a_r, tvalid_r;
    logic [103:0]     tdata_r;
    logic             tick_s, accept_s, drop_s, busy_nx_s;
    logic             issue_s, capture_s, load_s;

    assign tick_s    = (cnt_r == CNT_LAST);
    assign accept_s  = tick_s & enable & (state_r == ST_IDLE) & ~tvalid_r;
    assign drop_s    = tick_s & enable & ~accept_s;
    assign busy_nx_s = (state_nx_s == ST_CS_SETUP) | (state_nx_s == ST_CMD) |
                       (state_nx_s == ST_DATA);

    assign bus.byte_start = byte_start_r;
    assign bus.byte_tx    = byte_tx_r;
    assign bus.SS_G       = ss_g_r;
    assign bus.SS_A       = ss_a_r;
    assign bus.TVALID     = tvalid_r;
    assign bus.TDATA      = tdata_r;
    assign overrun_cnt    = overrun_r;

    // Free-running sample timer; wraps on the tick cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Saturating count of ticks that could not start a read cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r <= 8'h00;
        end else if (drop_s && (overrun_r != 8'hFF)) begin
            overrun_r <= overrun_r + 8'd1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode plus per-cycle byte issue, capture and frame-load strobes.
    always_comb begin
        state_nx_s = state_r;
        sel_nx_s   = sel_r;
        issue_s    = 1'b0;
        issue_tx_s = 8'h00;
        capture_s  = 1'b0;
        load_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nx_s = ST_CS_SETUP;
                    sel_nx_s   = 1'b0;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CS_SETUP: begin
                state_nx_s = ST_CMD;
                issue_s    = 1'b1;
                issue_tx_s = sel_r ? ACCEL_CMD : GYRO_CMD;
            end
            ST_CMD: begin
                if (bus.byte_done) begin
                    state_nx_s = ST_DATA;
                    issue_s    = 1'b1;
                end else begin
                    state_nx_s = ST_CMD;
                end
            end
            ST_DATA: begin
                if (bus.byte_done) begin
                    capture_s = 1'b1;
                    if (byte_idx_r == 3'd5) begin
                        state_nx_s = ST_CS_RELEASE;
                    end else begin
                        state_nx_s = ST_DATA;
                        issue_s    = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
            ST_CS_RELEASE: begin
                if (sel_r) begin
                    state_nx_s = ST_OUTPUT;
                    load_s     = 1'b1;
                end else begin
                    state_nx_s = ST_GAP;
                    sel_nx_s   = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nx_s = ST_CS_SETUP;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_OUTPUT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // Byte bookkeeping, sample shift-in, frame register and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_start_r <= 1'b0;
            byte_tx_r    <= 8'h00;
            ss_g_r       <= 1'b1;
            ss_a_r       <= 1'b1;
            sel_r        <= 1'b0;
            byte_idx_r   <= 3'd0;
            gap_cnt_r    <= {GAP_W{1'b0}};
            gyro_r       <= 48'h0;
            accel_r      <= 48'h0;
            seq_r        <= 8'h00;
            tvalid_r     <= 1'b0;
            tdata_r      <= 104'h0;
        end else begin
            byte_start_r <= issue_s;
            if (issue_s) begin
                byte_tx_r <= issue_tx_s;
            end
            // Selects follow the next state so SS falls exactly as CS_SETUP begins.
            ss_g_r <= ~(busy_nx_s & ~sel_nx_s);
            ss_a_r <= ~(busy_nx_s & sel_nx_s);
            sel_r  <= sel_nx_s;
            if (state_r == ST_CMD) begin
                byte_idx_r <= 3'd0;
            end else if (capture_s) begin
                byte_idx_r <= byte_idx_r + 3'd1;
            end
            if (state_r == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_r <= {GAP_W{1'b0}};
            end
            if (capture_s && sel_r) begin
                accel_r <= {accel_r[39:0], bus.byte_rx};
            end
            if (capture_s && !sel_r) begin
                gyro_r <= {gyro_r[39:0], bus.byte_rx};
            end
            if (load_s) begin
                tdata_r  <= {seq_r, gyro_r, accel_r};
                seq_r    <= seq_r + 8'd1;
                tvalid_r <= 1'b1;
            end else if (tvalid_r && bus.TREADY) begin
                tvalid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_sensor_scheduler.sv
// Directed bench for spi_sensor_scheduler with a fixed-latency SPI byte model.
module tb_spi_sensor_scheduler;
    localparam int DIV = 160;
    localparam int GAP = 4;
    localparam int L   = 8;
    localparam logic [47:0] G_DATA = 48'h111213141516;
    localparam logic [47:0] A_DATA = 48'h212223242526;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] tx;
        logic       ss_g;
        logic       ss_a;
        int         delta;
    } vec_t;

    typedef struct {
        logic [7:0] tx;
        logic       ss_g;
        logic       ss_a;
        int         cyc;
    } tr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] overrun_cnt;

    spi_sensor_scheduler_if bus();

    spi_sensor_scheduler #(
        .SAMPLE_DIV(DIV), .GYRO_CMD(8'hE8), .ACCEL_CMD(8'hE8), .CS_GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .overrun_cnt(overrun_cnt), .bus(bus)
    );

    always #5 clk = ~clk;

    vec_t vec[$];
    tr_t  trace[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // SPI byte engine: byte_done L cycles after byte_start, rx taken from the vector table.
    int rem = 0, cur_idx = 0, xfer_k = 0;
    always @(negedge clk) begin
        if (reset) begin
            rem           <= 0;
            xfer_k        <= 0;
            bus.byte_done <= 1'b0;
            bus.byte_rx   <= 8'h00;
        end else begin
            bus.byte_done <= 1'b0;
            if (rem == 1) begin
                bus.byte_done <= 1'b1;
                bus.byte_rx   <= (cur_idx < vec.size()) ? vec[cur_idx].rx : 8'h00;
            end
            if (rem > 0) rem <= rem - 1;
            if (bus.byte_start) begin
                rem     <= L;
                cur_idx <= (bus.SS_A ? 0 : 7) + xfer_k;
                xfer_k  <= xfer_k + 1;
            end else if (bus.SS_G && bus.SS_A) begin
                xfer_k <= 0;
            end
        end
    end

    // Bus monitor: byte trace, select run lengths, gap length and TVALID timing.
    int   cyc = 0, g_run = 0, a_run = 0, hi_run = 0, g_last = 0, a_last = 0;
    int   gap_last = 0, both_low = 0, tv_run = 0, tv_last = 0, rise_cyc = 0;
    logic tv_prev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.byte_start) trace.push_back('{bus.byte_tx, bus.SS_G, bus.SS_A, cyc});
        if (!bus.SS_G) g_run <= g_run + 1;
        else if (g_run != 0) begin g_last <= g_run; g_run <= 0; end
        if (!bus.SS_A) a_run <= a_run + 1;
        else if (a_run != 0) begin a_last <= a_run; a_run <= 0; end
        if (bus.SS_G && bus.SS_A) hi_run <= hi_run + 1;
        else begin
            if (!bus.SS_A && hi_run != 0) gap_last <= hi_run;
            hi_run <= 0;
        end
        if (!bus.SS_G && !bus.SS_A) both_low <= both_low + 1;
        if (bus.TVALID) begin
            tv_run <= tv_run + 1;
            if (!tv_prev) rise_cyc <= cyc;
        end else if (tv_run != 0) begin
            tv_last <= tv_run;
            tv_run  <= 0;
        end
        tv_prev <= bus.TVALID;
    end

    task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic wait_tvalid(input string name, input int bound);
        int i = 0;
        while (!bus.TVALID && i < bound) begin step(1); i++; end
        check(name, 104'(bus.TVALID), 104'h1);
    endtask

    task automatic wait_ssg_low(input string name, input int bound);
        int i = 0;
        while (bus.SS_G && i < bound) begin step(1); i++; end
        check(name, 104'(bus.SS_G), 104'h0);
    endtask

    logic [103:0] hold;
    int base, bad, i;

    initial begin
        // {rx returned, expected tx, expected SS_G, expected SS_A, cycles since previous byte_start}
        vec.push_back('{8'hA5, 8'hE8, 1'b0, 1'b1, 0});
        vec.push_back('{8'h11, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h12, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h13, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h14, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h15, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h16, 8'h00, 1'b0, 1'b1, 9});
        vec.push_back('{8'h5A, 8'hE8, 1'b1, 1'b0, 15});
        vec.push_back('{8'h21, 8'h00, 1'b1, 1'b0, 9});
        vec.push_back('{8'h22, 8'h00, 1'b1, 1'b0, 9});
        vec.push_back('{8'h23, 8'h00, 1'b1, 1'b0, 9});
        vec.push_back('{8'h24, 8'h00, 1'b1, 1'b0, 9});
        vec.push_back('{8'h25, 8'h00, 1'b1, 1'b0, 9});
        vec.push_back('{8'h26, 8'h00, 1'b1, 1'b0, 9});

        reset = 1'b1; enable = 1'b0; bus.TREADY = 1'b0;
        step(3);
        check("rst_byte_start", 104'(bus.byte_start), 104'h0);
        check("rst_byte_tx", 104'(bus.byte_tx), 104'h0);
        check("rst_ss_g", 104'(bus.SS_G), 104'h1);
        check("rst_ss_a", 104'(bus.SS_A), 104'h1);
        check("rst_tvalid", 104'(bus.TVALID), 104'h1 ^ 104'h1);
        check("rst_tdata", bus.TDATA, 104'h0);
        check("rst_overrun", 104'(overrun_cnt), 104'h0);

        // First frame with immediate acceptance
        reset = 1'b0; enable = 1'b1; bus.TREADY = 1'b1;
        base = trace.size();
        wait_tvalid("frame0_timeout", 2 * DIV + 200);
        check("frame0_tdata", bus.TDATA, {8'h00, G_DATA, A_DATA});
        step(2);
        check("frame0_valid_len", 104'(tv_last), 104'h1);
        check("frame0_tvalid_clear", 104'(bus.TVALID), 104'h0);
        check("frame0_nbytes", 104'(trace.size() - base), 104'd14);
        for (int k = 0; k < 14 && base + k < trace.size(); k++) begin
            check($sformatf("xfer%0d_tx", k), 104'(trace[base + k].tx), 104'(vec[k].tx));
            check($sformatf("xfer%0d_ss_g", k), 104'(trace[base + k].ss_g), 104'(vec[k].ss_g));
            check($sformatf("xfer%0d_ss_a", k), 104'(trace[base + k].ss_a), 104'(vec[k].ss_a));
            if (k > 0)
                check($sformatf("xfer%0d_spacing", k),
                      104'(trace[base + k].cyc - trace[base + k - 1].cyc), 104'(vec[k].delta));
        end
        check("ss_g_low_cycles", 104'(g_last), 104'd64);
        check("ss_a_low_cycles", 104'(a_last), 104'd64);
        check("cs_gap_cycles", 104'(gap_last), 104'd5);
        if (base < trace.size())
            check("start_to_tvalid", 104'(rise_cyc - trace[base].cyc), 104'd133);

        wait_tvalid("frame1_timeout", DIV + 100);
        check("frame1_tdata", bus.TDATA, {8'h01, G_DATA, A_DATA});

        // Backpressure for three sample periods
        step(1);
        bus.TREADY = 1'b0;
        wait_tvalid("frame2_timeout", DIV + 100);
        check("frame2_tdata", bus.TDATA, {8'h02, G_DATA, A_DATA});
        hold = bus.TDATA;
        bad = 0;
        for (int k = 0; k < 3 * DIV; k++) begin
            step(1);
            if (!bus.TVALID || bus.TDATA !== hold) bad++;
        end
        check("hold_stable", 104'(bad), 104'h0);
        check("hold_overrun", 104'(overrun_cnt), 104'd3);
        bus.TREADY = 1'b1;
        step(1);
        check("hold_release", 104'(bus.TVALID), 104'h0);
        wait_tvalid("frame3_timeout", DIV + 200);
        check("frame3_tdata", bus.TDATA, {8'h03, G_DATA, A_DATA});
        check("frame3_overrun", 104'(overrun_cnt), 104'd3);

        // enable dropped mid-cycle: frame completes, then no activity and no overruns
        wait_ssg_low("frame4_start", DIV + 50);
        step(5);
        enable = 1'b0; bus.TREADY = 1'b0;
        wait_tvalid("frame4_timeout", 300);
        check("frame4_tdata", bus.TDATA, {8'h04, G_DATA, A_DATA});
        base = trace.size();
        step(2 * DIV);
        check("disabled_no_start", 104'(trace.size() - base), 104'h0);
        check("disabled_no_overrun", 104'(overrun_cnt), 104'd3);
        bus.TREADY = 1'b1;
        step(DIV);
        check("disabled_no_start2", 104'(trace.size() - base), 104'h0);

        // Overrun saturation
        enable = 1'b1; bus.TREADY = 1'b0;
        wait_tvalid("frame5_timeout", DIV + 200);
        step(100 * DIV);
        check("overrun_103", 104'(overrun_cnt), 104'd103);
        step(200 * DIV);
        check("overrun_saturated", 104'(overrun_cnt), 104'd255);

        // Async reset with the third gyro data byte in flight
        bus.TREADY = 1'b1;
        step(1);
        wait_ssg_low("rst_frame_start", DIV + 50);
        base = trace.size();
        i = 0;
        while (trace.size() < base + 4 && i < 100) begin step(1); i++; end
        check("rst_third_data_start", 104'(trace.size() - base), 104'd4);
        step(3);
        #2 reset = 1'b1;
        #1;
        check("async_rst_ss_g", 104'(bus.SS_G), 104'h1);
        check("async_rst_ss_a", 104'(bus.SS_A), 104'h1);
        check("async_rst_tvalid", 104'(bus.TVALID), 104'h0);
        check("async_rst_overrun", 104'(overrun_cnt), 104'h0);
        step(3);
        reset = 1'b0;
        wait_tvalid("post_rst_timeout", 2 * DIV + 200);
        check("post_rst_tdata", bus.TDATA, {8'h00, G_DATA, A_DATA});
        check("never_both_low", 104'(both_low), 104'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
